// File: rtl/parking_occupancy_counter.sv
// parking_occupancy_counter
//
// Counts cars in a single-lane lot using two photo-beam sensors: a (outer)
// and b (inner). A direction-detecting FSM tracks each full crossing. The
// occupancy count saturates at 0 and at MAX_COUNT and never wraps.
//
// Parameters:
//   MAX_COUNT   lot capacity, 1..99 (the downstream display shows two digits)
//
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous, active-high reset
//   a       in   outer sensor, 1 = beam blocked (asynchronous)
//   b       in   inner sensor, 1 = beam blocked (asynchronous)
//   count   out  occupancy, 7-bit unsigned, 0..MAX_COUNT
//   enter   out  one-cycle pulse when a valid entry completes
//   exit    out  one-cycle pulse when a valid exit completes
//   full    out  count == MAX_COUNT
//   empty   out  count == 0
//   err     out  sticky error flag (present only when OCC_ERR_EN is defined)
//
// Build option:
//   OCC_ERR_EN  adds the err port. err is set on a saturated enter, a
//               saturated exit, or entry into WAIT_CLR, and is cleared only
//               by reset.
//
// FSM states (s = {a_s, b_s}):
//   state    | meaning
//   IDLE     | no car in the beams
//   EN_A     | entering: only the outer beam is blocked
//   EN_AB    | entering: both beams are blocked
//   EN_B     | entering: only the inner beam is blocked
//   EX_B     | exiting: only the inner beam is blocked
//   EX_AB    | exiting: both beams are blocked
//   EX_A     | exiting: only the outer beam is blocked
//   WAIT_CLR | sequence not recognised; wait for both beams to clear

module parking_occupancy_counter #(
    parameter int MAX_COUNT = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a,
    input  logic       b,
    output logic [6:0] count,
    output logic       enter,
    output logic       exit,
    output logic       full,
`ifdef OCC_ERR_EN
    output logic       empty,
    output logic       err
`else
    output logic       empty
`endif
);

    if (MAX_COUNT < 1 || MAX_COUNT > 99) begin : g_bad_max_count
        $error("parking_occupancy_counter: MAX_COUNT must be in 1..99");
    end

    localparam logic [6:0] MAX_C = 7'(MAX_COUNT);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EN_A     = 3'd1,
        EN_AB    = 3'd2,
        EN_B     = 3'd3,
        EX_B     = 3'd4,
        EX_AB    = 3'd5,
        EX_A     = 3'd6,
        WAIT_CLR = 3'd7
    } state_t;

    state_t     state_q, state_d;
    logic       a_m, a_s, b_m, b_s;
    logic [1:0] s;
    logic       enter_d, exit_d;

    // Two-flop synchronizers for the asynchronous sensor inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_m <= 1'b0;
            a_s <= 1'b0;
            b_m <= 1'b0;
            b_s <= 1'b0;
        end else begin
            a_m <= a;
            a_s <= a_m;
            b_m <= b;
            b_s <= b_m;
        end
    end

    assign s = {a_s, b_s};

    always_comb begin
        state_d = state_q;
        enter_d = 1'b0;
        exit_d  = 1'b0;
        case (state_q)
            IDLE: begin
                case (s)
                    2'b10:   state_d = EN_A;
                    2'b01:   state_d = EX_B;
                    2'b11:   state_d = WAIT_CLR;
                    default: state_d = IDLE;
                endcase
            end
            EN_A: begin
                case (s)
                    2'b11:   state_d = EN_AB;
                    2'b00:   state_d = IDLE;
                    2'b01:   state_d = WAIT_CLR;
                    default: state_d = EN_A;
                endcase
            end
            EN_AB: begin
                case (s)
                    2'b01:   state_d = EN_B;
                    2'b10:   state_d = EN_A;
                    2'b00:   state_d = IDLE;
                    default: state_d = EN_AB;
                endcase
            end
            EN_B: begin
                case (s)
                    2'b00: begin
                        state_d = IDLE;
                        enter_d = 1'b1;
                    end
                    2'b11:   state_d = EN_AB;
                    2'b10:   state_d = WAIT_CLR;
                    default: state_d = EN_B;
                endcase
            end
            EX_B: begin
                case (s)
                    2'b11:   state_d = EX_AB;
                    2'b00:   state_d = IDLE;
                    2'b10:   state_d = WAIT_CLR;
                    default: state_d = EX_B;
                endcase
            end
            EX_AB: begin
                case (s)
                    2'b10:   state_d = EX_A;
                    2'b01:   state_d = EX_B;
                    2'b00:   state_d = IDLE;
                    default: state_d = EX_AB;
                endcase
            end
            EX_A: begin
                case (s)
                    2'b00: begin
                        state_d = IDLE;
                        exit_d  = 1'b1;
                    end
                    2'b11:   state_d = EX_AB;
                    2'b01:   state_d = WAIT_CLR;
                    default: state_d = EX_A;
                endcase
            end
            WAIT_CLR: begin
                if (s == 2'b00) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The pulses and the count update land on the same edge that returns
    // the FSM to IDLE. A saturated count holds, but the pulse still fires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            enter   <= 1'b0;
            exit    <= 1'b0;
            count   <= 7'd0;
        end else begin
            state_q <= state_d;
            enter   <= enter_d;
            exit    <= exit_d;
            if (enter_d && (count != MAX_C))
                count <= count + 7'd1;
            else if (exit_d && (count != 7'd0))
                count <= count - 7'd1;
        end
    end

`ifdef OCC_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err <= 1'b0;
        else if ((enter_d && (count == MAX_C)) ||
                 (exit_d && (count == 7'd0)) ||
                 ((state_d == WAIT_CLR) && (state_q != WAIT_CLR)))
            err <= 1'b1;
    end
`endif

    assign full  = (count == MAX_C);
    assign empty = (count == 7'd0);

endmodule

// File: tb/tb_parking_occupancy_counter.sv
module tb_parking_occupancy_counter;

    logic       clk;
    logic       reset;
    logic       a;
    logic       b;
    logic [6:0] count;
    logic       enter;
    logic       exit;
    logic       full;
    logic       empty;
`ifdef OCC_ERR_EN
    logic       err;
`endif

    int checks;
    int errors;
    int n_enter;
    int n_exit;

    parking_occupancy_counter #(.MAX_COUNT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .count (count),
        .enter (enter),
        .exit  (exit),
        .full  (full),
`ifdef OCC_ERR_EN
        .empty (empty),
        .err   (err)
`else
        .empty (empty)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (enter) n_enter++;
        if (exit)  n_exit++;
    end

    // Holds {a,b} = v for n rising edges; returns 1 time unit after the last one.
    task automatic seq(input logic [1:0] v, input int n);
        {a, b} = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_entry();
        seq(2'b10, 4);
        seq(2'b11, 4);
        seq(2'b01, 4);
        seq(2'b00, 4);
    endtask

    task automatic do_exit();
        seq(2'b01, 4);
        seq(2'b11, 4);
        seq(2'b10, 4);
        seq(2'b00, 4);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {a, b} = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        {a, b} = 2'b00;
        #2;
        checks++;
        if (count !== 7'd0 || enter !== 1'b0 || exit !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: count=%0d enter=%b exit=%b empty=%b full=%b, want 0 0 0 1 0",
                     count, enter, exit, empty, full);
        end
`ifdef OCC_ERR_EN
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: err=%b want 0", err);
        end
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_entry();
        int e0;
        e0 = n_enter;
        seq(2'b10, 4);
        seq(2'b11, 4);
        seq(2'b01, 4);
        {a, b} = 2'b00;
        @(posedge clk); #1;
        checks++;
        if (enter !== 1'b0 || count !== 7'd0) begin
            errors++;
            $display("FAIL entry_edge1: enter=%b count=%0d want 0 0", enter, count);
        end
        @(posedge clk); #1;
        checks++;
        if (enter !== 1'b0 || count !== 7'd0) begin
            errors++;
            $display("FAIL entry_edge2: enter=%b count=%0d want 0 0", enter, count);
        end
        @(posedge clk); #1;
        checks++;
        if (enter !== 1'b1 || exit !== 1'b0 || count !== 7'd1 || empty !== 1'b0) begin
            errors++;
            $display("FAIL entry_edge3: enter=%b exit=%b count=%0d empty=%b want 1 0 1 0",
                     enter, exit, count, empty);
        end
        @(posedge clk); #1;
        checks++;
        if (enter !== 1'b0 || count !== 7'd1) begin
            errors++;
            $display("FAIL entry_edge4: enter=%b count=%0d want 0 1", enter, count);
        end
        seq(2'b00, 2);
        checks++;
        if (n_enter - e0 !== 1) begin
            errors++;
            $display("FAIL entry_pulses: got %0d want 1", n_enter - e0);
        end
    endtask

    task automatic test_exit();
        int x0;
        int e0;
        x0 = n_exit;
        e0 = n_enter;
        do_exit();
        checks++;
        if (count !== 7'd0 || empty !== 1'b1 || n_exit - x0 !== 1 || n_enter - e0 !== 0) begin
            errors++;
            $display("FAIL exit_basic: count=%0d empty=%b exits=%0d enters=%0d want 0 1 1 0",
                     count, empty, n_exit - x0, n_enter - e0);
        end
    endtask

    task automatic test_abort();
        int e0;
        int x0;
        do_entry();
        e0 = n_enter;
        x0 = n_exit;
        seq(2'b10, 4);
        seq(2'b11, 4);
        seq(2'b10, 4);
        seq(2'b00, 6);
        checks++;
        if (count !== 7'd1 || n_enter - e0 !== 0 || n_exit - x0 !== 0) begin
            errors++;
            $display("FAIL abort_backout: count=%0d enters=%0d exits=%0d want 1 0 0",
                     count, n_enter - e0, n_exit - x0);
        end
`ifdef OCC_ERR_EN
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL abort_err_clear: err=%b want 0", err);
        end
`endif
        seq(2'b11, 4);
        seq(2'b01, 4);
        seq(2'b00, 6);
        checks++;
        if (count !== 7'd1 || n_enter - e0 !== 0 || n_exit - x0 !== 0) begin
            errors++;
            $display("FAIL abort_waitclr: count=%0d enters=%0d exits=%0d want 1 0 0",
                     count, n_enter - e0, n_exit - x0);
        end
`ifdef OCC_ERR_EN
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL abort_err_set: err=%b want 1", err);
        end
`endif
    endtask

    task automatic test_saturation();
        logic [6:0] exp_up [4];
        logic [6:0] exp_dn [4];
        int e0;
        int x0;
        exp_up[0] = 7'd1; exp_up[1] = 7'd2; exp_up[2] = 7'd3; exp_up[3] = 7'd3;
        exp_dn[0] = 7'd2; exp_dn[1] = 7'd1; exp_dn[2] = 7'd0; exp_dn[3] = 7'd0;
        do_reset();
        e0 = n_enter;
        x0 = n_exit;
        for (int i = 0; i < 4; i++) begin
`ifdef OCC_ERR_EN
            if (i == 3) begin
                checks++;
                if (err !== 1'b0) begin
                    errors++;
                    $display("FAIL sat_err_before: err=%b want 0", err);
                end
            end
`endif
            do_entry();
            checks++;
            if (count !== exp_up[i]) begin
                errors++;
                $display("FAIL sat_up_%0d: count=%0d want %0d", i, count, exp_up[i]);
            end
        end
        checks++;
        if (full !== 1'b1 || empty !== 1'b0 || n_enter - e0 !== 4) begin
            errors++;
            $display("FAIL sat_full: full=%b empty=%b enters=%0d want 1 0 4",
                     full, empty, n_enter - e0);
        end
`ifdef OCC_ERR_EN
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL sat_err_full: err=%b want 1", err);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            do_exit();
            checks++;
            if (count !== exp_dn[i]) begin
                errors++;
                $display("FAIL sat_dn_%0d: count=%0d want %0d", i, count, exp_dn[i]);
            end
        end
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || n_exit - x0 !== 4) begin
            errors++;
            $display("FAIL sat_empty: empty=%b full=%b exits=%0d want 1 0 4",
                     empty, full, n_exit - x0);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        do_entry();
        do_entry();
        checks++;
        if (count !== 7'd2) begin
            errors++;
            $display("FAIL midrun_pre: count=%0d want 2", count);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (count !== 7'd0 || enter !== 1'b0 || exit !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL midrun_async: count=%0d enter=%b exit=%b empty=%b full=%b want 0 0 0 1 0",
                     count, enter, exit, empty, full);
        end
`ifdef OCC_ERR_EN
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL midrun_err: err=%b want 0", err);
        end
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_seq();
        int e0;
        int x0;
        seq(2'b00, 2);
        e0 = n_enter;
        x0 = n_exit;
        seq(2'b10, 4);
        seq(2'b11, 4);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        seq(2'b01, 4);
        seq(2'b00, 6);
        checks++;
        if (count !== 7'd0 || n_enter - e0 !== 0 || n_exit - x0 !== 0) begin
            errors++;
            $display("FAIL midseq: count=%0d enters=%0d exits=%0d want 0 0 0",
                     count, n_enter - e0, n_exit - x0);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        n_enter = 0;
        n_exit  = 0;
        reset   = 1'b1;
        a       = 1'b0;
        b       = 1'b0;
        test_reset();
        test_entry();
        test_exit();
        test_abort();
        test_saturation();
        test_reset_mid_run();
        test_reset_mid_seq();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
